// File: rtl/fm_ram_pkg.sv
// Shared encodings, FSM states and byte-lane decode for the FM RAM ports.
package fm_ram_pkg;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_OKAY,
        ST_RAW_WAIT,
        ST_ERR1,
        ST_ERR2
    } fm_state_t;

    // Zero mask marks an illegal size/alignment combination.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] ofs,
        input logic [2:0] size
    );
        logic [3:0] m;
        m = 4'h0;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << ofs;
            HSIZE_HALF: m = ofs[0] ? 4'h0 : (4'b0011 << ofs);
            HSIZE_WORD: m = (ofs == 2'b00) ? 4'hf : 4'h0;
            default:    m = 4'h0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fm_ram_rdmux.sv
// Bank read-data select with byte-wise merge of forwarded write data.
module fm_ram_rdmux #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_BITS = 2
) (
    input  logic [32*NUM_BANKS-1:0] rdata,
    input  logic [BANK_BITS-1:0]    bank,
    input  logic [31:0]             fwd_data,
    input  logic [3:0]              fwd_mask,
    output logic [31:0]             hrdata
);

    logic [31:0] ram_word;

    assign ram_word = rdata[{bank, 5'b00000} +: 32];

    always_comb begin
        hrdata = ram_word;
        for (int i = 0; i < 4; i++) begin
            if (fwd_mask[i]) begin
                hrdata[8*i +: 8] = fwd_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahblite_fm_ram_banked.sv
// AHB-Lite port onto NUM_BANKS feature-map RAMs with RAW stall and ERROR.
// FMRAM_RAW_FWD_EN replaces the RAW stall with write-data forwarding.
module ahblite_fm_ram_banked
    import fm_ram_pkg::*;
#(
    parameter int FM_ADDR_WIDTH = 6,
    parameter int NUM_BANKS     = 4,
    parameter int WIN_WIDTH     = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HSIZE,
    input  logic [3:0]               HPROT,
    input  logic                     HWRITE,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic                     HREADYOUT,
    output logic [31:0]              HRDATA,
    output logic                     HRESP,
    output logic [FM_ADDR_WIDTH-1:0] FM_RDADDR,
    output logic [NUM_BANKS-1:0]     FM_RDEN,
    input  logic [32*NUM_BANKS-1:0]  FM_RDATA,
    output logic [FM_ADDR_WIDTH-1:0] FM_WRADDR,
    output logic [31:0]              FM_WDATA,
    output logic [4*NUM_BANKS-1:0]   FM_WRITE
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int WIN_LO    = FM_ADDR_WIDTH + 2 + BANK_BITS;

    fm_state_t state, state_nxt;

    logic                     trans, oor, err;
    logic                     rd_legal, wr_legal;
    logic                     hazard, stall, advance;
    logic [FM_ADDR_WIDTH-1:0] word, word_q;
    logic [BANK_BITS-1:0]     bank, bank_q;
    logic [3:0]               mask, mask_q;
    logic                     wr_q;
    logic [31:0]              fwd_data;
    logic [3:0]               fwd_mask;
    logic                     unused;

    assign unused = ^{HPROT, HADDR >> WIN_WIDTH};

    assign trans = HSEL & HREADY &
                   (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign word  = HADDR[FM_ADDR_WIDTH+1:2];
    assign bank  = HADDR[FM_ADDR_WIDTH+2 +: BANK_BITS];
    assign mask  = lane_mask(HADDR[1:0], HSIZE);

    generate
        if (WIN_WIDTH > WIN_LO) begin : g_oor
            assign oor = |HADDR[WIN_WIDTH-1:WIN_LO];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    assign err      = trans & (oor | (mask == 4'h0));
    assign rd_legal = trans & ~err & ~HWRITE;
    assign wr_legal = trans & ~err & HWRITE;
    assign hazard   = rd_legal & wr_q &
                      (bank == bank_q) & (word == word_q);
    assign advance  = HREADY & HREADYOUT;

`ifdef FMRAM_RAW_FWD_EN
    logic        fwd_v;
    logic [31:0] fwd_wdata;
    logic [3:0]  fwd_wmask;

    assign stall = 1'b0;

    // Snapshot the landing write so the next read can see it at once.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_v     <= 1'b0;
            fwd_wdata <= 32'h0;
            fwd_wmask <= 4'h0;
        end else if (advance) begin
            fwd_v     <= hazard;
            fwd_wdata <= HWDATA;
            fwd_wmask <= mask_q;
        end
    end

    assign fwd_data = fwd_wdata;
    assign fwd_mask = fwd_v ? fwd_wmask : 4'h0;
`else
    assign stall    = hazard;
    assign fwd_data = 32'h0;
    assign fwd_mask = 4'h0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_OKAY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_OKAY, ST_ERR2: begin
                if (err) begin
                    state_nxt = ST_ERR1;
                end else if (stall) begin
                    state_nxt = ST_RAW_WAIT;
                end else begin
                    state_nxt = ST_OKAY;
                end
            end
            ST_RAW_WAIT: state_nxt = ST_OKAY;
            ST_ERR1:     state_nxt = ST_ERR2;
            default:     state_nxt = ST_OKAY;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        unique case (state)
            ST_RAW_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q   <= 1'b0;
            word_q <= '0;
            bank_q <= '0;
            mask_q <= 4'h0;
        end else if (advance) begin
            wr_q <= wr_legal;
            if (rd_legal | wr_legal) begin
                word_q <= word;
                bank_q <= bank;
                mask_q <= mask;
            end
        end
    end

    // The stall cycle re-reads the word now that the write has landed.
    always_comb begin
        FM_RDADDR = '0;
        FM_RDEN   = '0;
        if (state == ST_RAW_WAIT) begin
            FM_RDADDR = word_q;
            FM_RDEN   = {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank_q;
        end else if (rd_legal) begin
            FM_RDADDR = word;
            FM_RDEN   = {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank;
        end
    end

    assign FM_WRADDR = word_q;
    assign FM_WDATA  = HWDATA;

    always_comb begin
        FM_WRITE = '0;
        if (wr_q) begin
            FM_WRITE[{bank_q, 2'b00} +: 4] = mask_q;
        end
    end

    fm_ram_rdmux #(
        .NUM_BANKS(NUM_BANKS),
        .BANK_BITS(BANK_BITS)
    ) u_rdmux (
        .rdata    (FM_RDATA),
        .bank     (bank_q),
        .fwd_data (fwd_data),
        .fwd_mask (fwd_mask),
        .hrdata   (HRDATA)
    );

endmodule

// File: tb/tb_ahblite_fm_ram_banked.sv
// Bench for ahblite_fm_ram_banked: directed and random AHB traffic
// against a word-array reference memory and a behavioural banked RAM.
module tb_ahblite_fm_ram_banked;

    localparam int FMW   = 6;
    localparam int NB    = 4;
    localparam int WIN   = 16;
    localparam int DEPTH = 1 << FMW;
    localparam int LO    = FMW + 2 + 2;

`ifdef FMRAM_RAW_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            HCLK;
    logic            HRESETn;
    logic            HSEL;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic [2:0]      HSIZE;
    logic [3:0]      HPROT;
    logic            HWRITE;
    logic [31:0]     HWDATA;
    logic            HREADY;
    logic            HREADYOUT;
    logic [31:0]     HRDATA;
    logic            HRESP;
    logic [FMW-1:0]  FM_RDADDR;
    logic [NB-1:0]   FM_RDEN;
    logic [32*NB-1:0] FM_RDATA;
    logic [FMW-1:0]  FM_WRADDR;
    logic [31:0]     FM_WDATA;
    logic [4*NB-1:0] FM_WRITE;

    ahblite_fm_ram_banked #(
        .FM_ADDR_WIDTH(FMW),
        .NUM_BANKS(NB),
        .WIN_WIDTH(WIN)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .FM_RDADDR(FM_RDADDR),
        .FM_RDEN(FM_RDEN), .FM_RDATA(FM_RDATA), .FM_WRADDR(FM_WRADDR),
        .FM_WDATA(FM_WDATA), .FM_WRITE(FM_WRITE)
    );

    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Behavioural synchronous RAM banks, 1-cycle read latency, read-old.
    logic [31:0] ram   [NB*DEPTH];
    logic [31:0] ram_q [NB];

    always @(posedge HCLK) begin
        for (int b = 0; b < NB; b++) begin
            if (FM_RDEN[b]) ram_q[b] <= ram[b*DEPTH + int'(FM_RDADDR)];
            for (int k = 0; k < 4; k++) begin
                if (FM_WRITE[4*b+k])
                    ram[b*DEPTH + int'(FM_WRADDR)][8*k +: 8] <= FM_WDATA[8*k +: 8];
            end
        end
    end

    always_comb begin
        FM_RDATA = '0;
        for (int b = 0; b < NB; b++) FM_RDATA[32*b +: 32] = ram_q[b];
    end

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [NB*DEPTH];

    bit          p_v, p_w, p_err, p_haz;
    int          p_idx;
    logic [3:0]  p_mask;
    logic [31:0] p_wd, p_exp;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_mask(input logic [1:0] ofs,
                                            input logic [2:0] sz);
        int n, o;
        o = int'(ofs);
        if (sz > 3'd2) return 4'h0;
        n = 1 << sz;
        if (o % n != 0) return 4'h0;
        return 4'(((1 << n) - 1) << o);
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return ((a >> LO) & ((32'h1 << (WIN - LO)) - 1)) == 0;
    endfunction

    // One address phase; also completes and checks the previous data phase.
    task automatic step(input bit v, input bit w, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
        logic [3:0]    m;
        bit            legal, haz, resp0;
        int            idx, waits, exp_waits;
        logic [NB-1:0] exp_rden;
        logic [4*NB-1:0] exp_wr;
        m     = ref_mask(a[1:0], sz);
        idx   = int'((a >> 2) & (NB*DEPTH - 1));
        legal = v && (m != 4'h0) && in_window(a);
        haz   = legal && !w && p_v && p_w && !p_err && (p_idx == idx);
        HSEL   = v;
        HTRANS = v ? 2'b10 : 2'b00;
        HADDR  = a;
        HSIZE  = sz;
        HWRITE = w;
        HWDATA = (p_v && p_w) ? p_wd : $urandom;
        #1;
        resp0 = HRESP;
        waits = 0;
        while (HREADYOUT !== 1'b1 && waits < 4) begin
            check("stall_fm_write", FM_WRITE, '0);
            @(negedge HCLK);
            #1;
            waits++;
        end
        exp_waits = (p_v && (p_err || (p_haz && !FWD))) ? 1 : 0;
        check("wait_states", waits, exp_waits);
        if (p_v && p_err) begin
            check("err_resp_first", resp0, 1'b1);
            check("err_resp_last", HRESP, 1'b1);
        end else begin
            check("okay_resp", HRESP, 1'b0);
        end
        if (p_v && !p_err && !p_w) check("hrdata", HRDATA, p_exp);
        exp_wr = '0;
        if (p_v && p_w && !p_err)
            exp_wr = 16'(p_mask) << (4 * (p_idx / DEPTH));
        check("fm_write", FM_WRITE, exp_wr);
        exp_rden = '0;
        if (legal && !w) begin
            exp_rden = 4'b0001 << (idx / DEPTH);
            check("fm_rdaddr", FM_RDADDR, idx % DEPTH);
        end
        check("fm_rden", FM_RDEN, exp_rden);
        if (legal && w) begin
            for (int k = 0; k < 4; k++)
                if (m[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
        end
        p_v    = v;
        p_w    = w;
        p_err  = v && !legal;
        p_haz  = haz;
        p_idx  = idx;
        p_mask = m;
        p_wd   = wd;
        p_exp  = ref_mem[idx];
        @(negedge HCLK);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hreadyout"}, HREADYOUT, 1'b1);
        check({tag, "_hresp"}, HRESP, 1'b0);
        check({tag, "_fm_write"}, FM_WRITE, '0);
        check({tag, "_fm_rden"}, FM_RDEN, '0);
    endtask

    logic [31:0] ra, last_a;
    bit          rv, rw;
    logic [2:0]  rsz;

    initial begin
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HSIZE = '0;
        HPROT = '0; HWRITE = 1'b0; HWDATA = '0;
        p_v = 0; p_w = 0; p_err = 0; p_haz = 0; p_idx = 0;
        p_mask = '0; p_wd = '0; p_exp = '0;
        for (int i = 0; i < NB*DEPTH; i++) ref_mem[i] = 32'h0;

        repeat (2) @(negedge HCLK);
        #1;
        check_reset_outputs("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Prefill words 0..7 of every bank.
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < 8; w++)
                step(1, 1, 32'(b*256 + w*4), 3'd2, $urandom);
        idle();

        // Word write bank 2 word 5, then a non-adjacent read.
        step(1, 1, 32'h214, 3'd2, 32'hDEADBEEF);
        idle();
        step(1, 0, 32'h214, 3'd2, 32'h0);
        idle();

        // Byte write at offset 3 followed at once by a word read.
        step(1, 1, 32'h104, 3'd2, 32'h11223344);
        idle();
        step(1, 1, 32'h107, 3'd0, 32'hAA000000);
        step(1, 0, 32'h104, 3'd2, 32'h0);
        idle();
        check("raw_merge_ref", ref_mem[32'h41], 32'hAA223344);

        // Out-of-window read, then illegal half and word alignments.
        step(1, 0, 32'h800, 3'd2, 32'h0);
        idle();
        step(1, 1, 32'h101, 3'd1, 32'h12345678);
        step(1, 1, 32'h102, 3'd2, 32'h9ABCDEF0);
        idle();

        // Back-to-back writes, one per bank.
        step(1, 1, 32'h010, 3'd2, 32'h00000001);
        step(1, 1, 32'h110, 3'd2, 32'h00000002);
        step(1, 1, 32'h210, 3'd2, 32'h00000003);
        step(1, 1, 32'h310, 3'd2, 32'h00000004);
        idle();
        step(1, 0, 32'h210, 3'd2, 32'h0);
        idle();

        // Random traffic biased towards reusing the previous address.
        last_a = 32'h0;
        for (int n = 0; n < 300; n++) begin
            rv = ($urandom_range(0, 9) != 0);
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 4) begin
                ra = last_a;
            end else begin
                ra = (32'($urandom_range(0, 3)) << 8) |
                     (32'($urandom_range(0, 7)) << 2) |
                     32'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0)
                    ra = ra | (32'h1 << (LO + $urandom_range(0, 5)));
            end
            rsz = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            step(rv, rw, ra, rsz, $urandom);
            last_a = ra;
        end
        idle();

        // Reset asserted during ERR1.
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h800;
        HWRITE = 1'b0; HSIZE = 3'd2;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        #1;
        check("err1_hreadyout", HREADYOUT, 1'b0);
        check("err1_hresp", HRESP, 1'b1);
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("rst_err1");
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst1_fm_write", FM_WRITE, '0);
            check("post_rst1_hreadyout", HREADYOUT, 1'b1);
            @(negedge HCLK);
        end

        // Reset asserted during a write data phase: the write is dropped.
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h018;
        HWRITE = 1'b1; HSIZE = 3'd2;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HWDATA = 32'h5555AAAA;
        #1;
        check("wrdp_fm_write", FM_WRITE, 16'h000F);
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("rst_wrdp");
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst2_fm_write", FM_WRITE, '0);
            @(negedge HCLK);
        end
        step(1, 0, 32'h018, 3'd2, 32'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahblite_fm_ram_banked.md
Name: ahblite_fm_ram_banked

Overview:
- AHB-Lite subordinate that fronts NUM_BANKS feature-map block RAMs of 2^FM_ADDR_WIDTH 32-bit words each, mapped contiguously.
- Generalises the single-bank FM data port in three ways:
  - bank decode;
  - read-after-write hazard handling, where a read immediately following a write to the same word gets one wait state;
  - two-cycle ERROR response for out-of-window addresses and illegal size/alignment.
- Sits on the AHB-Lite matrix between the CPU and the accelerator feature-map memory.

Parameters:
- FM_ADDR_WIDTH, 6: word-address bits per bank.
- NUM_BANKS, 4: bank count; power of two, at least 2. Derived localparam BANK_BITS = clog2(NUM_BANKS).
- WIN_WIDTH, 16: log2 of the decoded byte window. Must be at least FM_ADDR_WIDTH+2+BANK_BITS.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset
- HSEL  in  1  slave select
- HADDR  in  32  address
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size
- HPROT  in  4  unused
- HWRITE  in  1  write
- HWDATA  in  32  write data
- HREADY  in  1  bus ready
- HREADYOUT  out  1  slave ready
- HRDATA  out  32  read data
- HRESP  out  1  error response
- FM_RDADDR  out  FM_ADDR_WIDTH  read word address, shared by all banks
- FM_RDEN  out  NUM_BANKS  one-hot read enable
- FM_RDATA  in  32*NUM_BANKS  bank read data; bank b is in bits [32b+31:32b]
- FM_WRADDR  out  FM_ADDR_WIDTH  write word address
- FM_WDATA  out  32  write data
- FM_WRITE  out  4*NUM_BANKS  byte strobes per bank

Clock and reset are fixed: a single clock HCLK; reset HRESETn is asynchronous and active-low.

Behaviour:
- Address decode:
  - trans = HSEL & HTRANS[1] & HREADY.
  - word = HADDR[FM_ADDR_WIDTH+1:2].
  - bank = HADDR[FM_ADDR_WIDTH+2 +: BANK_BITS].
  - oor = any bit of HADDR[WIN_WIDTH-1 : FM_ADDR_WIDTH+2+BANK_BITS] set.
- Byte lanes (from {HADDR[1:0],HSIZE[1:0]}):
  - Byte at offset 0/1/2/3 gives 1/2/4/8.
  - Half at offset 0/2 gives 3/c.
  - Word at offset 0 gives f.
  - Anything else is illegal (mask 0).
- Error: a transfer with oor or an illegal size is accepted as an error transfer. It never produces FM_WRITE or FM_RDEN.
- Reads:
  - In the address phase, FM_RDADDR = word and FM_RDEN = one-hot(bank); all zero if no legal read.
  - RAMs are synchronous with 1-cycle latency.
  - In the data phase, HRDATA = slice of FM_RDATA selected by the registered bank.
- Writes:
  - In the address phase, register word, bank and mask.
  - In the data phase, drive FM_WRADDR = word_q, FM_WDATA = HWDATA, and FM_WRITE[bank_q*4+:4] = mask_q; all other strobes are 0.
  - Zero-wait writes.
- FSM states: OKAY, RAW_WAIT, ERR1, ERR2.
- OKAY: HREADYOUT=1, HRESP=0.
  - Legal trans with no hazard: stay in OKAY.
  - Error trans: go to ERR1.
  - Legal read whose bank/word equals the pending write data phase (wr_q valid): go to RAW_WAIT.
- RAW_WAIT: HREADYOUT=0, HRESP=0.
  - Re-drive FM_RDADDR = word_q and FM_RDEN for bank_q; the write has now landed.
  - Next state is OKAY, where data is returned.
  - HADDR is ignored during this cycle. The master holds it, and it is re-sampled when HREADY=1.
- ERR1: HREADYOUT=0, HRESP=1. Next state is ERR2.
- ERR2: HREADYOUT=1, HRESP=1. Next state is OKAY.
  - A new transfer presented during ERR2 is decoded normally, because HREADY=1.
- Hazard and strobe rules:
  - A write followed by a read to a different word or bank has no wait.
  - A read followed by a write has no hazard.
  - Back-to-back writes stream at one per cycle.
- Reset: asynchronous; may be asserted mid-transfer.
  - Reset values: state=OKAY, HREADYOUT=1, HRESP=0, FM_WRITE=0, FM_RDEN=0, all address/data registers 0, wr_q=0.
  - After reset, no stale strobe is ever issued.
- HRDATA is don't-care outside read data phases; it is still driven from the mux and is never X-propagated from an unselected bank.

Optional Feature:
- Macro FMRAM_RAW_FWD_EN.
- Defined:
  - RAW_WAIT is never entered.
  - HWDATA and mask are captured at the end of the write data phase.
  - The following read data phase returns HRDATA in which each byte with the captured mask bit set is taken from the captured write data; other bytes come from the RAM.
  - Zero wait states.
- Undefined: the one-wait-state stall described above.

Decomposition:
- Package fm_ram_pkg holds:
  - the HTRANS/HSIZE encodings;
  - the FSM state enum;
  - the byte-lane decode function, shared with the single-bank port.
- One natural sub-module: fm_ram_rdmux, the NUM_BANKS:1 read-data mux plus the optional byte-merge forwarding.

Test Plan:
- Word write 0xDEADBEEF to bank 2 word 5, then a non-adjacent read: FM_WRITE = 0x0F00 one cycle; the read returns 0xDEADBEEF with zero waits.
- Byte write 0xAA at offset 3, immediately followed by a word read of the same word:
  - With the macro undefined: one HREADYOUT=0 cycle, then the merged value with byte 3 = 0xAA.
  - With the macro defined: zero waits, same data.
- Read to an address with a window bit above the bank field set, e.g. HADDR=0x0000_0800 with the defaults: HRESP=1 with HREADYOUT 0 then 1; FM_RDEN stays 0.
- Half-word at offset 1, and a word at offset 2: error response; FM_WRITE stays 0 throughout.
- Four back-to-back writes, one to each bank: FM_WRITE = 0x000F, 0x00F0, 0x0F00, 0xF000 on consecutive cycles.
- Assert HRESETn low during ERR1 and during a write data phase: all outputs at reset values immediately; no FM_WRITE pulse after release.
